// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state type and sizing helpers for the sequential signed divider
package seq_divider_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, FIX = 2'd2} state_t;
   localparam int DEFAULT_WIDTH = 8;
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on unsigned magnitudes
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   rem,
   input  logic [WIDTH-1:0] dq,
   input  logic [WIDTH-1:0] dmag,
   output logic [WIDTH:0]   rem_next,
   output logic [WIDTH-1:0] dq_next
);
   logic [WIDTH+1:0] trial;
   always_comb begin
      trial = {rem, dq[WIDTH-1]} - {2'b00, dmag};
      rem_next = trial[WIDTH+1] ? {rem[WIDTH-1:0], dq[WIDTH-1]} : trial[WIDTH:0];
      dq_next = {dq[WIDTH-2:0], ~trial[WIDTH+1]};
   end
endmodule

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: multi-cycle signed divider, one quotient bit per clock plus a sign-fix cycle
module seq_signed_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);
   localparam int CW = cnt_width(WIDTH);
   state_t state;
   logic [CW-1:0] cnt;
   logic [WIDTH:0] rem, rem_n;
   logic [WIDTH-1:0] dq, dq_n, dmag, a_q;
   logic sign_q, sign_r, zero, ovf;
   div_step #(.WIDTH(WIDTH)) u_step (.rem(rem), .dq(dq), .dmag(dmag), .rem_next(rem_n), .dq_next(dq_n));
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         done <= 1'b0;
         quotient <= '0;
         remainder <= '0;
         div_by_zero <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
               sign_r <= dividend[WIDTH-1];
               dq <= dividend[WIDTH-1] ? -dividend : dividend;
               dmag <= divisor[WIDTH-1] ? -divisor : divisor;
               rem <= '0;
               a_q <= dividend;
               zero <= divisor == '0;
               ovf <= dividend == {1'b1, {(WIDTH-1){1'b0}}} && divisor == '1;
               // a zero divisor takes a single throw-away step so its latency is two clocks
               cnt <= divisor == '0 ? CW'(WIDTH - 1) : '0;
               state <= DIV;
            end
            DIV: begin
               rem <= rem_n;
               dq <= dq_n;
               cnt <= cnt + 1'b1;
               state <= cnt == CW'(WIDTH - 1) ? FIX : DIV;
            end
            FIX: begin
               done <= 1'b1;
               state <= IDLE;
               cnt <= '0;
               quotient <= zero ? '1 : sign_q ? -dq : dq;
               remainder <= zero ? a_q : sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
               div_by_zero <= zero;
               overflow <= ovf & ~zero;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
